matrix_ram_loader: RTL and testbench



---
 rtl/matrix_ram_loader_if.sv | 35 +++
 rtl/matrix_ram_loader.sv | 120 ++++++++++++
 tb/tb_matrix_ram_loader.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_ram_loader_if.sv
// Job control, 32-bit stream and RAM write-port bundle for matrix_ram_loader.
// master = the loader, slave = the job source / stream producer / RAM side.
interface matrix_ram_loader_if #(
   parameter int IN_DEPTH  = 64,
   parameter int COE_DEPTH = 8192
);
   localparam int InAw  = $clog2(IN_DEPTH);
   localparam int CoeAw = $clog2(COE_DEPTH);

   logic             start;
   logic [3:0]       target;
   logic [CoeAw-1:0] base_adrs;
   logic [CoeAw:0]   num_words;
   logic             s_valid;
   logic [31:0]      s_data;
   logic             s_ready;
   logic [7:0]       in_ram_wen;
   logic [InAw-1:0]  in_ram_wadrs;
   logic             coe_in_wen;
   logic [CoeAw-1:0] coe_in_wadrs;
   logic [255:0]     wdat;
   logic             busy;
   logic             done;
   logic             err;

   modport master (
      input  start, target, base_adrs, num_words, s_valid, s_data,
      output s_ready, in_ram_wen, in_ram_wadrs, coe_in_wen, coe_in_wadrs, wdat, busy, done, err
   );

   modport slave (
      output start, target, base_adrs, num_words, s_valid, s_data,
      input  s_ready, in_ram_wen, in_ram_wadrs, coe_in_wen, coe_in_wadrs, wdat, busy, done, err
   );
endinterface

// File: rtl/matrix_ram_loader.sv
// Packs 8 stream words into one 256-bit word and writes it to in_ramN or coe_in.
// MATRIX_LOADER_MSB_FIRST_EN: first stream word of each RAM word lands in wdat[255:224].
module matrix_ram_loader #(
   parameter int IN_DEPTH  = 64,
   parameter int COE_DEPTH = 8192
) (
   input logic                 clk_250MHz,
   input logic                 rst,
   matrix_ram_loader_if.master bus
);
   localparam int InAw  = $clog2(IN_DEPTH);
   localparam int CoeAw = $clog2(COE_DEPTH);
   localparam int EndW  = CoeAw + 2;

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StFill  = 2'd1;
   localparam logic [1:0] StWrite = 2'd2;
   localparam logic [1:0] StDone  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [3:0]       target_q;
   logic [CoeAw-1:0] base_q;
   logic [CoeAw:0]   num_q;
   logic [CoeAw:0]   idx_q;
   logic [2:0]       beat_q;
   logic [255:0]     fill_q, fill_d;
   logic [255:0]     wdat_q;
   logic [InAw-1:0]  in_adrs_q;
   logic [CoeAw-1:0] coe_adrs_q;
   logic             err_q;

   logic [EndW-1:0]  end_adrs;
   logic             start_err;
   logic             beat;
   logic [2:0]       lane;
   logic [CoeAw-1:0] wr_adrs;

   assign end_adrs  = {2'b00, bus.base_adrs} + {1'b0, bus.num_words};
   assign start_err = (bus.target > 4'd8)
                    || ((bus.target < 4'd8) && (end_adrs > EndW'(IN_DEPTH)))
                    || ((bus.target == 4'd8) && (end_adrs > EndW'(COE_DEPTH)));

   assign beat    = bus.s_valid && (state_q == StFill);
   assign wr_adrs = base_q + idx_q[CoeAw-1:0];

`ifdef MATRIX_LOADER_MSB_FIRST_EN
   assign lane = 3'd7 - beat_q;
`else
   assign lane = beat_q;
`endif

   always_comb begin
      fill_d = fill_q;
      fill_d[32*lane +: 32] = bus.s_data;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (bus.start) begin
               if (start_err || (bus.num_words == '0)) state_d = StDone;
               else                                    state_d = StFill;
            end
         end
         StFill:  if (beat && (beat_q == 3'd7)) state_d = StWrite;
         StWrite: state_d = ((idx_q + 1'b1) == num_q) ? StDone : StFill;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_250MHz or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         target_q   <= '0;
         base_q     <= '0;
         num_q      <= '0;
         idx_q      <= '0;
         beat_q     <= '0;
         fill_q     <= '0;
         wdat_q     <= '0;
         in_adrs_q  <= '0;
         coe_adrs_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         if ((state_q == StIdle) && bus.start) begin
            target_q <= bus.target;
            base_q   <= bus.base_adrs;
            num_q    <= bus.num_words;
            idx_q    <= '0;
            beat_q   <= '0;
            err_q    <= start_err;
         end
         if (beat) begin
            fill_q <= fill_d;
            beat_q <= beat_q + 3'd1;
            // Publish the full word and its address only on the 8th beat so wdat stays stable.
            if (beat_q == 3'd7) begin
               wdat_q <= fill_d;
               if (target_q == 4'd8) coe_adrs_q <= wr_adrs;
               else                  in_adrs_q  <= wr_adrs[InAw-1:0];
            end
         end
         if (state_q == StWrite) idx_q <= idx_q + 1'b1;
      end
   end

   assign bus.s_ready      = (state_q == StFill);
   assign bus.busy         = (state_q == StFill) || (state_q == StWrite);
   assign bus.done         = (state_q == StDone);
   assign bus.err          = err_q;
   assign bus.wdat         = wdat_q;
   assign bus.in_ram_wadrs = in_adrs_q;
   assign bus.coe_in_wadrs = coe_adrs_q;
   assign bus.in_ram_wen   = ((state_q == StWrite) && (target_q < 4'd8)) ?
                             (8'd1 << target_q[2:0]) : 8'd0;
   assign bus.coe_in_wen   = (state_q == StWrite) && (target_q == 4'd8);
endmodule

// File: tb/tb_matrix_ram_loader.sv
// Scoreboard bench for matrix_ram_loader: stimulus pushes expected writes/done pulses,
// a negedge monitor pops and compares them.
module tb_matrix_ram_loader;
   localparam int IN_DEPTH  = 64;
   localparam int COE_DEPTH = 8192;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #2 clk = ~clk;

   matrix_ram_loader_if #(.IN_DEPTH(IN_DEPTH), .COE_DEPTH(COE_DEPTH)) bus ();

   matrix_ram_loader #(.IN_DEPTH(IN_DEPTH), .COE_DEPTH(COE_DEPTH)) dut (
      .clk_250MHz(clk),
      .rst       (rst),
      .bus       (bus.master)
   );

   typedef struct {
      int           cyc;
      logic [7:0]   in_wen;
      logic [5:0]   in_adrs;
      logic         coe_wen;
      logic [12:0]  coe_adrs;
      logic [255:0] wdat;
   } wr_t;

   typedef struct {
      int   cyc;
      logic err;
   } dn_t;

   wr_t wr_q[$];
   dn_t dn_q[$];
   int  checks   = 0;
   int  errors   = 0;
   int  ecount   = 0;
   int  job_edge = 0;
   bit  no_ready = 1'b0;

   always @(posedge clk) ecount <= ecount + 1;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] exp_word(input logic [31:0] first);
      logic [255:0] r = '0;
      for (int b = 0; b < 8; b++) begin
`ifdef MATRIX_LOADER_MSB_FIRST_EN
         r[32*(7-b) +: 32] = first + 32'(b);
`else
         r[32*b +: 32] = first + 32'(b);
`endif
      end
      return r;
   endfunction

   always @(negedge clk) begin : monitor
      int  rel;
      wr_t e;
      dn_t d;
      rel = ecount - job_edge + 1;
      if (!rst) begin
         if ((|bus.in_ram_wen) || bus.coe_in_wen) begin
            if (wr_q.size() == 0) begin
               chk("unexpected_write", {bus.in_ram_wen, bus.coe_in_wen}, '0);
            end else begin
               e = wr_q.pop_front();
               chk("write_cycle", rel, e.cyc);
               chk("in_ram_wen", bus.in_ram_wen, e.in_wen);
               chk("coe_in_wen", bus.coe_in_wen, e.coe_wen);
               if (e.coe_wen) chk("coe_in_wadrs", bus.coe_in_wadrs, e.coe_adrs);
               else           chk("in_ram_wadrs", bus.in_ram_wadrs, e.in_adrs);
               chk("wdat", bus.wdat, e.wdat);
            end
         end
         if (bus.done) begin
            if (dn_q.size() == 0) begin
               chk("unexpected_done", bus.done, 1'b0);
            end else begin
               d = dn_q.pop_front();
               chk("done_cycle", rel, d.cyc);
               chk("done_err", bus.err, d.err);
               chk("done_busy", bus.busy, 1'b0);
            end
         end
         if (no_ready) chk("s_ready_short_job", bus.s_ready, 1'b0);
      end
   end

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_s_ready"}, bus.s_ready, 1'b0);
      chk({tag, "_in_ram_wen"}, bus.in_ram_wen, 8'h00);
      chk({tag, "_coe_in_wen"}, bus.coe_in_wen, 1'b0);
      chk({tag, "_busy"}, bus.busy, 1'b0);
      chk({tag, "_done"}, bus.done, 1'b0);
      chk({tag, "_err"}, bus.err, 1'b0);
      chk({tag, "_wdat"}, bus.wdat, '0);
      chk({tag, "_in_ram_wadrs"}, bus.in_ram_wadrs, 6'd0);
      chk({tag, "_coe_in_wadrs"}, bus.coe_in_wadrs, 13'd0);
   endtask

   // alt: s_valid toggles 1,0,1,0 from the first cycle of each word's fill.
   // hold: start stays high with altered fields for the whole job.
   task automatic run_job(input int tgt, input int base, input int num, input logic [31:0] first,
                          input bit alt, input bit hold);
      int  p;
      bit  e;
      bit  rdy;
      int  bt;
      int  ph;
      int  guard;
      e = (tgt > 8) || ((tgt < 8) && (base + num > IN_DEPTH))
          || ((tgt == 8) && (base + num > COE_DEPTH));
      p = alt ? 16 : 9;
      if (e || (num == 0)) begin
         dn_q.push_back('{1, e});
      end else begin
         for (int w = 0; w < num; w++) begin
            wr_q.push_back('{p * (w + 1), (tgt < 8) ? 8'(1 << tgt) : 8'h00, 6'(base + w),
                             (tgt == 8), 13'(base + w), exp_word(first + 32'(8 * w))});
         end
         dn_q.push_back('{p * num + 1, 1'b0});
      end
      bus.start     = 1'b1;
      bus.target    = 4'(tgt);
      bus.base_adrs = 13'(base);
      bus.num_words = 14'(num);
      if (e || (num == 0)) begin
         no_ready    = 1'b1;
         bus.s_valid = 1'b1;
         bus.s_data  = 32'hdead_beef;
      end
      @(posedge clk);
      #1;
      job_edge = ecount;
      if (hold) begin
         bus.target    = 4'(tgt ^ 5);
         bus.base_adrs = 13'(base + 3);
         bus.num_words = 14'(num + 1);
      end else begin
         bus.start = 1'b0;
      end
      if (!(e || (num == 0))) begin
         for (int w = 0; w < num; w++) begin
            bt    = 0;
            ph    = 0;
            guard = 0;
            while ((bt < 8) && (guard < 100)) begin
               bus.s_valid = alt ? (ph % 2 == 0) : 1'b1;
               bus.s_data  = first + 32'(8 * w + bt);
               rdy         = bus.s_ready;
               @(posedge clk);
               if (bus.s_valid && rdy) bt++;
               ph++;
               guard++;
               #1;
            end
            if (guard >= 100) chk("beat_timeout", guard, 0);
            bus.s_valid = 1'b0;
            @(posedge clk);
            #1;
         end
      end
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      no_ready    = 1'b0;
      bus.s_valid = 1'b0;
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      bus.start     = 1'b0;
      bus.target    = '0;
      bus.base_adrs = '0;
      bus.num_words = '0;
      bus.s_valid   = 1'b0;
      bus.s_data    = '0;
      #1;
      chk_zero_outputs("reset");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      run_job(2, 5, 2, 32'h0, 1'b0, 1'b0);          // input RAM, continuous stream
      run_job(8, 8190, 2, 32'h1000, 1'b0, 1'b0);    // coefficient RAM at top of range
      run_job(0, 0, 0, 32'h0, 1'b0, 1'b0);          // zero-length
      run_job(4, 0, 1, 32'h2000, 1'b1, 1'b0);       // backpressure
      run_job(6, 20, 2, 32'h3000, 1'b0, 1'b1);      // start held during job
      run_job(9, 0, 1, 32'h0, 1'b0, 1'b0);          // illegal target
      run_job(0, 60, 5, 32'h0, 1'b0, 1'b0);         // range error, err stays set

      // Reset after beat 4 of word 0: nothing expected from this job.
      bus.start     = 1'b1;
      bus.target    = 4'd3;
      bus.base_adrs = 13'd10;
      bus.num_words = 14'd2;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      for (int b = 0; b < 4; b++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = 32'h4000 + 32'(b);
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      #1;
      chk_zero_outputs("midjob_reset");
      bus.s_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      run_job(3, 10, 1, 32'h5000, 1'b0, 1'b0);

      chk("writes_pending", 32'(wr_q.size()), 0);
      chk("dones_pending", 32'(dn_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
